// File: rtl/reg_fifo_pkg.sv
// Shared types and sizing helpers for the reg_fifo word buffer.
package reg_fifo_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int DEPTH_DEFAULT = 4;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  // Pointer width; a 1-entry FIFO would still need a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // COUNT must be able to hold DEPTH itself, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_fifo_if.sv
// Upstream/downstream handshake bundle for reg_fifo; master drives data in and consumer ready.
interface reg_fifo_if
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
);

  // Handshake: a word moves on a rising edge when its valid and ready are both high;
  // valid must not depend on ready, and O stays stable while O_VALID=1 and O_READY=0.
  logic [WIDTH-1:0]        I;
  logic                    I_VALID;
  logic                    I_READY;
  logic [WIDTH-1:0]        O;
  logic                    O_VALID;
  logic                    O_READY;
  logic [cnt_w(DEPTH)-1:0] COUNT;

  modport master (
    output I, I_VALID, O_READY,
    input  I_READY, O, O_VALID, COUNT
  );

  modport slave (
    input  I, I_VALID, O_READY,
    output I_READY, O, O_VALID, COUNT
  );

endinterface

// File: rtl/reg_fifo_mem.sv
// DEPTH x WIDTH storage for reg_fifo: synchronous write, asynchronous read, async reset to INIT.
module reg_fifo_mem
  import reg_fifo_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEFAULT,
  parameter int               DEPTH = DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               PW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/reg_fifo.sv
// First-word-fall-through FIFO behind the register stage; pointers, occupancy and handshake.
// Optional zero-latency empty bypass is built when REG_FIFO_BYPASS_EN is defined.
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEFAULT,
  parameter int               DEPTH = DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic        CLK,
  input  logic        ARST_N,
  reg_fifo_if.slave   bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head_data;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef REG_FIFO_BYPASS_EN
  logic bypass;

  // An empty FIFO with a willing consumer hands the word straight through
  // instead of storing it, so nothing is written in that case.
  assign bypass = empty & bus.I_VALID & bus.O_READY;
  assign push   = bus.I_VALID & ~full & ~bypass;
  assign pop    = ~empty & bus.O_READY;

  assign bus.O       = bypass ? bus.I : head_data;
  assign bus.O_VALID = ~empty | bypass;
`else
  assign push = bus.I_VALID & ~full;
  assign pop  = ~empty & bus.O_READY;

  assign bus.O       = head_data;
  assign bus.O_VALID = ~empty;
`endif

  assign bus.I_READY = ~full;
  assign bus.COUNT   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  reg_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INIT  (INIT),
    .PW    (PW)
  ) u_mem (
    .clk    (CLK),
    .arst_n (ARST_N),
    .we     (push),
    .waddr  (wr_ptr_q),
    .wdata  (bus.I),
    .raddr  (rd_ptr_q),
    .rdata  (head_data)
  );

endmodule

// File: tb/tb_reg_fifo.sv
// Bench for reg_fifo: queue reference model compared every cycle, plus directed literal checks.
// Bypass expectations follow REG_FIFO_BYPASS_EN.
module tb_reg_fifo;
  import reg_fifo_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic arst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic cmp_en = 1'b0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] got_q[$];

  reg_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT('0)) dut (
    .CLK    (clk),
    .ARST_N (arst_n),
    .bus    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_bypass();
`ifdef REG_FIFO_BYPASS_EN
    return (model_q.size() == 0) && bus.I_VALID && bus.O_READY;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      model_q.delete();
    end else if (!model_bypass()) begin
      logic do_pop;
      logic do_push;
      do_pop  = (model_q.size() != 0) && bus.O_READY;
      do_push = bus.I_VALID && (model_q.size() != DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(bus.I);
    end
  end

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic             exp_valid;
      logic [WIDTH-1:0] exp_o;
      exp_valid = (model_q.size() != 0) || model_bypass();
      exp_o     = model_bypass() ? bus.I : ((model_q.size() != 0) ? model_q[0] : '0);
      check("model_count", 32'(bus.COUNT), 32'(model_q.size()));
      check("model_i_ready", 32'(bus.I_READY), 32'(model_q.size() != DEPTH));
      check("model_o_valid", 32'(bus.O_VALID), 32'(exp_valid));
      if (exp_valid) check("model_o", 32'(bus.O), 32'(exp_o));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    @(posedge clk);
    #1;
    bus.I_VALID = iv;
    bus.I       = d;
    bus.O_READY = ordy;
    @(negedge clk);
  endtask

  initial begin
    int idx;
    arst_n      = 1'b0;
    bus.I       = '0;
    bus.I_VALID = 1'b0;
    bus.O_READY = 1'b0;

    // Reset held with clock running.
    repeat (3) @(negedge clk);
    check("rst_o_valid", 32'(bus.O_VALID), 32'd0);
    check("rst_i_ready", 32'(bus.I_READY), 32'd1);
    check("rst_count", 32'(bus.COUNT), 32'd0);
    check("rst_o", 32'(bus.O), 32'h0000);
    cmp_en = 1'b1;
    @(posedge clk);
    #1 arst_n = 1'b1;

    // Fill, then an ignored fifth push.
    drive(1'b1, 16'h1111, 1'b0);
    drive(1'b1, 16'h2222, 1'b0);
    drive(1'b1, 16'h3333, 1'b0);
    drive(1'b1, 16'h4444, 1'b0);
    drive(1'b1, 16'h5555, 1'b0);
    check("fill_count", 32'(bus.COUNT), 32'd4);
    check("fill_i_ready", 32'(bus.I_READY), 32'd0);
    drive(1'b1, 16'h5555, 1'b1);
    check("full_count", 32'(bus.COUNT), 32'd4);
    check("drain_o0", 32'(bus.O), 32'h1111);
    drive(1'b0, 16'h0000, 1'b1);
    check("drain_o1", 32'(bus.O), 32'h2222);
    check("drain_count1", 32'(bus.COUNT), 32'd3);
    drive(1'b0, 16'h0000, 1'b1);
    check("drain_o2", 32'(bus.O), 32'h3333);
    drive(1'b0, 16'h0000, 1'b1);
    check("drain_o3", 32'(bus.O), 32'h4444);
    drive(1'b0, 16'h0000, 1'b0);
    check("drain_o_valid", 32'(bus.O_VALID), 32'd0);
    check("drain_count", 32'(bus.COUNT), 32'd0);

    // Simultaneous push and pop at COUNT=2.
    drive(1'b1, 16'h0B01, 1'b0);
    drive(1'b1, 16'h0B02, 1'b0);
    drive(1'b1, 16'hAAAA, 1'b1);
    check("sim_count", 32'(bus.COUNT), 32'd2);
    check("sim_o0", 32'(bus.O), 32'h0B01);
    drive(1'b0, 16'h0000, 1'b1);
    check("sim_count2", 32'(bus.COUNT), 32'd2);
    check("sim_o1", 32'(bus.O), 32'h0B02);
    drive(1'b0, 16'h0000, 1'b1);
    check("sim_o2", 32'(bus.O), 32'hAAAA);
    check("sim_count3", 32'(bus.COUNT), 32'd1);
    drive(1'b0, 16'h0000, 1'b0);

    // Asynchronous reset with two entries queued, no clock edge.
    drive(1'b1, 16'h0C01, 1'b0);
    drive(1'b1, 16'h0C02, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    check("pre_arst_count", 32'(bus.COUNT), 32'd2);
    #1 arst_n = 1'b0;
    #1;
    check("arst_count", 32'(bus.COUNT), 32'd0);
    check("arst_o_valid", 32'(bus.O_VALID), 32'd0);
    check("arst_o", 32'(bus.O), 32'h0000);
    @(posedge clk);
    #1 arst_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b1);
    check("post_arst_count", 32'(bus.COUNT), 32'd0);

    // Wrap: ten words with O_READY toggling.
    idx = 0;
    got_q.delete();
    for (int c = 0; c < 60 && got_q.size() < 10; c++) begin
      drive(idx < 10, 16'(idx + 1), c[0]);
      check("wrap_count_max", 32'(bus.COUNT <= 4), 32'd1);
      if (bus.I_VALID && bus.I_READY) idx++;
      if (bus.O_VALID && bus.O_READY) got_q.push_back(bus.O);
    end
    check("wrap_n_out", 32'(got_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < got_q.size(); k++) begin
      check("wrap_order", 32'(got_q[k]), 32'(k + 1));
    end
    drive(1'b0, 16'h0000, 1'b0);

    // Empty-FIFO latency, with and without the bypass.
    drive(1'b1, 16'hBEEF, 1'b1);
`ifdef REG_FIFO_BYPASS_EN
    check("byp_o", 32'(bus.O), 32'hBEEF);
    check("byp_o_valid", 32'(bus.O_VALID), 32'd1);
    check("byp_count", 32'(bus.COUNT), 32'd0);
    drive(1'b0, 16'h0000, 1'b0);
    check("byp_count_after", 32'(bus.COUNT), 32'd0);
`else
    check("nobyp_o_valid", 32'(bus.O_VALID), 32'd0);
    drive(1'b0, 16'h0000, 1'b1);
    check("nobyp_o", 32'(bus.O), 32'hBEEF);
    check("nobyp_count", 32'(bus.COUNT), 32'd1);
    drive(1'b0, 16'h0000, 1'b0);
    check("nobyp_count_after", 32'(bus.COUNT), 32'd0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0 ? (c % 40 < 20) : $urandom_range(0, 1)));
    end
    drive(1'b0, 16'h0000, 1'b1);
    repeat (5) drive(1'b0, 16'h0000, 1'b1);
    check("end_count", 32'(bus.COUNT), 32'd0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_fifo.md
Name: reg_fifo

Overview:
- Small synchronous FIFO that buffers the 16-bit word stream produced by the datapath register stage (my_register).
- Decouples that stage from a downstream consumer with valid/ready flow control, so the register output is not lost when the consumer stalls.
- Sits directly downstream of the register stage in the same clock domain.
- First-word-fall-through: the head entry is always presented on O.

Parameters:
- WIDTH, 16, data word width in bits; matches the register stage output.
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- INIT, 0, reset value of every storage entry and of O.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ARST_N  input  1  reset, asynchronous, active-low.
- I  input  WIDTH  write data from the upstream register stage.
- I_VALID  input  1  upstream offers I this cycle.
- I_READY  output  1  FIFO accepts I this cycle.
- O  output  WIDTH  head-of-queue data.
- O_VALID  output  1  O holds a valid word.
- O_READY  input  1  consumer takes O this cycle.
- COUNT  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- ARST_N low clears asynchronously, independent of CLK:
  - write pointer and read pointer = 0
  - COUNT = 0
  - all storage entries = INIT
- Output values while and after reset: O_VALID=0, I_READY=1, O=INIT, COUNT=0.
- A reset asserted mid-operation discards all queued data. The first edge after ARST_N rises behaves as from empty.
- push = I_VALID & I_READY; pop = O_VALID & O_READY. Both are evaluated at the rising edge of CLK.
- push: store I at wr_ptr, then wr_ptr += 1 modulo DEPTH (natural wrap, pointers are $clog2(DEPTH) bits).
- pop: rd_ptr += 1 modulo DEPTH.
- COUNT: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Combinational outputs, all derived from registered state:
  - I_READY = (COUNT != DEPTH)
  - O_VALID = (COUNT != 0)
  - O = storage[rd_ptr]
- Latency: a word pushed at edge N appears on O with O_VALID=1 after edge N. That is one cycle of latency, absent the optional bypass.
- Boundary conditions:
  - Full: I_READY=0, and I_VALID is ignored, even if O_READY=1 in the same cycle (no same-cycle refill when full).
  - Empty: O_VALID=0, and O_READY is ignored.
  - Simultaneous push and pop when neither full nor empty: both occur and COUNT is unchanged.
  - Pointer wrap is seamless; data order is strictly FIFO.
- No overflow or underflow is possible, given the rules above. O is stable while O_VALID=1 and O_READY=0.

Optional Feature:
- Macro: REG_FIFO_BYPASS_EN.
- Defined, applies only when COUNT==0, I_VALID=1 and O_READY=1:
  - I passes combinationally to O, with O_VALID=1.
  - No write occurs; pointers and COUNT are unchanged.
  - Latency for this case is 0 cycles.
  - In all other cases behaviour is identical to the default.
- Not defined: no combinational path from I/I_VALID to O/O_VALID. The empty-FIFO latency is always 1 cycle.

Decomposition:
- Shared package reg_fifo_pkg:
  - WIDTH_DEFAULT=16
  - DEPTH_DEFAULT=4
  - pointer and count width functions based on $clog2
  - a typedef for the data word
- One natural sub-module, reg_fifo_mem: the DEPTH×WIDTH storage.
  - Synchronous write port, asynchronous read port.
  - Async active-low reset to INIT.
- reg_fifo holds the pointers, COUNT, handshake logic and the bypass mux.

Test Plan:
- Reset: hold ARST_N=0, toggle CLK -> O_VALID=0, I_READY=1, COUNT=0, O=16'h0000. Assert ARST_N with no CLK edge while 2 entries are queued -> COUNT=0 immediately.
- Fill: O_READY=0, push 16'h1111, 2222, 3333, 4444 on consecutive cycles -> COUNT=4, I_READY=0. A fifth push of 16'h5555 with I_VALID=1 is dropped; COUNT stays 4.
- Drain: from full, O_READY=1 for 4 cycles -> O shows 1111, 2222, 3333, 4444 in order, then O_VALID=0 and COUNT=0.
- Simultaneous: with COUNT=2, push 16'hAAAA and pop in the same cycle -> COUNT stays 2, and AAAA emerges after the two older words.
- Wrap: stream 10 words, 16'h0001..16'h000A, with O_READY toggling every cycle -> output sequence matches input, no loss or duplication, COUNT never exceeds 4.
- Bypass, with REG_FIFO_BYPASS_EN defined: empty FIFO, I=16'hBEEF, I_VALID=1, O_READY=1 -> O=BEEF and O_VALID=1 in the same cycle, COUNT stays 0. Without the macro, BEEF appears one cycle later.
